// File: rtl/cfg_memory_burst.sv
// cfg_memory_burst: parametrised M x N configuration register file.
// Random single writes and registered reads, auto-incrementing burst writes,
// out-of-range detection, and a flat all_data_out bus for the datapath.
// Optional feature macro: CFG_MEM_CLEAR_EN compiles in the sequential clear
// engine (CLEAR state, clear_start path). Without it clear_start is ignored.
module cfg_memory_burst #(
    parameter int M = 102,
    parameter int N = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N-1:0]        data_in,
    input  logic [$clog2(M)-1:0] addr,
    input  logic                write_enable,
    input  logic                read_enable,
    input  logic                burst_start,
    input  logic [$clog2(M)-1:0] burst_len,
    input  logic                clear_start,
    output logic [N-1:0]        data_out,
    output logic [M*N-1:0]      all_data_out,
    output logic                busy,
    output logic                addr_error
);
    localparam int AW = $clog2(M);
    // One extra bit so the range check also works when M is a power of two.
    localparam logic [AW:0]   M_W  = (AW+1)'(M);
    localparam logic [AW-1:0] LAST = AW'(M-1);

`ifdef CFG_MEM_CLEAR_EN
    typedef enum logic [1:0] {S_IDLE, S_BURST, S_CLEAR} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_BURST} state_t;
    logic unused_clear_start;
    assign unused_clear_start = clear_start;
`endif

    state_t                   state_q, state_d;
    logic [AW-1:0]            ptr_q, ptr_d;
    logic [AW-1:0]            count_q, count_d;
    logic [N-1:0]             data_out_q, data_out_d;
    logic                     addr_err_q, addr_err_d;
    logic [M-1:0][N-1:0]      mem_q;

    // Single storage write port shared by IDLE writes, burst and clear.
    logic                     mem_we;
    logic [AW-1:0]            mem_wa;
    logic [N-1:0]             mem_wd;

    logic                     addr_ok;
    assign addr_ok = ({1'b0, addr} < M_W);

    // Next-state, storage write port and output updates.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        count_d    = count_q;
        data_out_d = data_out_q;
        addr_err_d = 1'b0;
        mem_we     = 1'b0;
        mem_wa     = ptr_q;
        mem_wd     = data_in;
        case (state_q)
            S_IDLE: begin
`ifdef CFG_MEM_CLEAR_EN
                if (clear_start) begin
                    state_d    = S_CLEAR;
                    ptr_d      = '0;
                    data_out_d = '0;
                end else
`endif
                if (burst_start) begin
                    if (addr_ok) begin
                        state_d = S_BURST;
                        ptr_d   = addr;
                        count_d = burst_len;
                    end else begin
                        addr_err_d = 1'b1;
                    end
                end else if (write_enable) begin
                    if (addr_ok) begin
                        mem_we     = 1'b1;
                        mem_wa     = addr;
                        data_out_d = data_in;
                    end else begin
                        addr_err_d = 1'b1;
                    end
                end else if (read_enable) begin
                    if (addr_ok) begin
                        data_out_d = mem_q[addr];
                    end else begin
                        data_out_d = '0;
                        addr_err_d = 1'b1;
                    end
                end
            end
            S_BURST: begin
                // No write_enable means the loader is stalling; just wait.
                if (write_enable) begin
                    mem_we     = 1'b1;
                    mem_wa     = ptr_q;
                    data_out_d = data_in;
                    ptr_d      = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
                    if (count_q == '0) state_d = S_IDLE;
                    else               count_d = count_q - 1'b1;
                end
            end
`ifdef CFG_MEM_CLEAR_EN
            S_CLEAR: begin
                mem_we = 1'b1;
                mem_wa = ptr_q;
                mem_wd = '0;
                if (ptr_q == LAST) begin
                    state_d = S_IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Control state and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            count_q    <= '0;
            data_out_q <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Storage array; only ever written through the shared port above.
    always_ff @(posedge clk) begin
        if (reset)       mem_q         <= '0;
        else if (mem_we) mem_q[mem_wa] <= mem_wd;
    end

    assign data_out     = data_out_q;
    assign addr_error   = addr_err_q;
    assign busy         = (state_q != S_IDLE);
    assign all_data_out = mem_q;
endmodule

// File: doc/cfg_memory_burst.md
# cfg_memory_burst

Parametrised configuration register file: M words of N bits, randomly writable, readable through a registered read port, and continuously exposed as a flat bus for downstream datapath logic (weights, thresholds, control bytes). It adds the following over the fixed 8-bit/102-byte store:
- parametrised geometry;
- auto-incrementing burst writes, so a serial loader can stream a block without driving addresses;
- a sequential clear engine;
- out-of-range detection.

It sits between the serial command front-end and the compute core.

## Interface
- M, 102, number of words (≥2)
- N, 8, word width in bits
- AW, $clog2(M), address width (derived localparam, not overridable)

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; clears all words and state
- data_in  in  N  write data
- addr  in  AW  write/read address; burst base address on burst_start
- write_enable  in  1  write strobe (single write in IDLE, next burst word in BURST)
- read_enable  in  1  read request, IDLE only
- burst_start  in  1  start burst at addr
- burst_len  in  AW  burst length minus one; sampled with burst_start
- clear_start  in  1  start sequential clear
- data_out  out  N  registered read/echo data
- all_data_out  out  M*N  word j on bits [j*N +: N]
- busy  out  1  high in BURST or CLEAR
- addr_error  out  1  one-cycle pulse on out-of-range access

## Operation
- One clock, clk. Synchronous active-high reset. Everything updates on the rising edge.
- Reset, when asserted at an edge, sets:
  - all words = 0;
  - data_out = 0, busy = 0, addr_error = 0;
  - state = IDLE, ptr = 0, count = 0.
- Reset asserted mid-burst or mid-clear aborts the operation and returns to IDLE.
- FSM states: IDLE, BURST, CLEAR.
- IDLE priority, highest first: clear_start > burst_start > write_enable > read_enable. Lower-priority requests in the same cycle are dropped.
- IDLE single write:
  - If addr < M: mem[addr] <= data_in, and data_out <= data_in (write echo).
  - If addr ≥ M: no write, data_out unchanged, addr_error pulses.
- IDLE read:
  - If addr < M: data_out <= mem[addr].
  - If addr ≥ M: data_out <= 0 and addr_error pulses.
- burst_start:
  - If addr ≥ M: addr_error pulses and the FSM stays in IDLE.
  - Otherwise: ptr <= addr, count <= burst_len, go to BURST. No data is written in the start cycle.
- BURST, on each cycle with write_enable:
  - mem[ptr] <= data_in and data_out <= data_in.
  - ptr wraps from M-1 to 0.
  - If count == 0, go to IDLE; else count decrements.
  - Cycles without write_enable stall the burst; there is no timeout.
  - burst_len+1 words are written in total. burst_len ≥ M overwrites earlier words after the wrap.
- CLEAR:
  - ptr <= 0 on entry.
  - Each cycle: mem[ptr] <= 0, ptr increments.
  - After the write to M-1, go to IDLE. The clear takes exactly M cycles in CLEAR.
  - data_out is forced to 0 on entry.
- While busy:
  - read_enable, burst_start and clear_start are ignored.
  - In CLEAR, write_enable is also ignored.
- all_data_out is combinational from the storage registers and has no reset-dependent gating.

## Timing
- Write → all_data_out: visible after the same edge that performs the write (1-cycle latency from strobe).
- Read: data_out is valid one cycle after read_enable and holds until the next update.
- busy:
  - rises on the edge that accepts burst_start or clear_start;
  - falls on the edge that performs the last burst write, or the write to word M-1 in CLEAR.
- A new command is accepted the cycle after busy falls.
- addr_error is high for exactly the one cycle following the offending edge. It is not sticky.
- Clear duration: M+1 cycles from the clear_start edge to the first accepted new command.

## Configuration
- CFG_MEM_CLEAR_EN defined: the CLEAR state and the clear_start path are compiled in, as described above.
- CFG_MEM_CLEAR_EN undefined:
  - The CLEAR state is absent and clear_start is ignored (the port remains).
  - Memory can be zeroed only by reset or by explicit writes.
  - All other behaviour is identical.

## Test plan
- Reset then random access (M=102, N=8):
  - write 0xA5 at addr 7 → all_data_out[63:56]=0xA5 next cycle, data_out=0xA5;
  - read addr 7 → data_out=0xA5 one cycle later.
- Out of range: write at addr 102 → no word changes, addr_error high for 1 cycle. Read at 110 → data_out=0, addr_error pulse.
- Burst with wrap:
  - setup: burst_start with addr=100, burst_len=3;
  - stimulus: data 0x11,0x22,0x33,0x44 with one stall cycle inserted;
  - required: mem[100]=0x11, mem[101]=0x22, mem[0]=0x33, mem[1]=0x44;
  - busy drops with the 4th write.
- Clear (CFG_MEM_CLEAR_EN):
  - setup: fill all words with 0xFF;
  - stimulus: pulse clear_start;
  - required: busy is high for 102 cycles, and all_data_out=0 afterwards;
  - required: write_enable during the clear has no effect.
- Priority and abort:
  - clear_start+burst_start+write_enable in the same cycle → CLEAR is entered and no write occurs;
  - reset asserted mid-burst → IDLE next cycle, all words 0, busy=0.
- Macro off: clear_start pulsed → busy stays 0 and memory is unchanged.
